// File: rtl/wrr_xbar_arb_if.sv
// Master-side and fabric-side bundle for the weighted round-robin arbiter/router.
interface wrr_xbar_arb_if #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned NUM_S = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned WT_W  = 4
);
  logic [NUM_M-1:0]      m_req;
  logic [NUM_M-1:0]      m_xfr;
  logic [NUM_M-1:0]      m_rw;
  logic [NUM_M*AW-1:0]   m_addr;
  logic [NUM_M*DW-1:0]   m_wdata;
  logic [NUM_M*WT_W-1:0] m_weight;
  logic [NUM_M-1:0]      m_grant;
  logic [NUM_M*DW-1:0]   m_rdata;
  logic [NUM_S-1:0]      s_sel;
  logic [NUM_S-1:0]      s_rw;
  logic [AW-1:0]         s_addr;
  logic [DW-1:0]         s_wdata;
  logic [NUM_S*DW-1:0]   s_rdata;
  logic                  dec_err;
  logic                  timeout;

  // Environment side: masters plus slave read-data return.
  modport master (
    output m_req, m_xfr, m_rw, m_addr, m_wdata, m_weight, s_rdata,
    input  m_grant, m_rdata, s_sel, s_rw, s_addr, s_wdata, dec_err, timeout
  );

  // Arbiter side.
  modport slave (
    input  m_req, m_xfr, m_rw, m_addr, m_wdata, m_weight, s_rdata,
    output m_grant, m_rdata, s_sel, s_rw, s_addr, s_wdata, dec_err, timeout
  );
endinterface

// File: rtl/wrr_xbar_arb.sv
// Weighted round-robin bus arbiter with address-decoded slave routing.
// Optional WRR_TIMEOUT_EN adds an idle-hold counter that force-releases a silent owner.
module wrr_xbar_arb #(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned NUM_S   = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned WT_W    = 4,
  parameter logic [15:0] BASE_HI = 16'hFFEF,
  parameter logic [3:0]  WIN_ID  = 4'h2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  wrr_xbar_arb_if.slave  bus
);
  localparam int unsigned PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t           r_state, w_state_nxt;
  logic [NUM_M-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]    r_owner, w_owner_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [WT_W-1:0]  r_credit, w_credit_nxt;

  logic             w_owned, w_own_req, w_own_xfr, w_release, w_hold_exp;
  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [31:0]      w_scan;
  logic [WT_W-1:0]  w_win_wt;
  logic [AW-1:0]    w_addr;
  logic             w_hit;

  assign w_owned   = (r_state == ST_OWNED);
  assign w_own_req = bus.m_req[r_owner];
  assign w_own_xfr = bus.m_xfr[r_owner];
  assign w_win_wt  = bus.m_weight[w_win*WT_W +: WT_W];

  // First requester starting at r_ptr, wrapping modulo NUM_M.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      w_scan = 32'(r_ptr) + i;
      if (w_scan >= NUM_M) w_scan = w_scan - NUM_M;
      if (!w_found && bus.m_req[PW'(w_scan)]) begin
        w_found = 1'b1;
        w_win   = PW'(w_scan);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_credit <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  // Release ends a tenure and hands over on the same edge, so there is no dead cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    w_release    = !w_owned || !w_own_req ||
                   (w_own_xfr && (r_credit == WT_W'(1))) || w_hold_exp;
    if (w_release) begin
      if (w_found) begin
        w_state_nxt  = ST_OWNED;
        w_grant_nxt  = NUM_M'(1) << w_win;
        w_owner_nxt  = w_win;
        w_ptr_nxt    = (w_win == PW'(NUM_M - 1)) ? '0 : w_win + PW'(1);
        w_credit_nxt = (w_win_wt == '0) ? WT_W'(1) : w_win_wt;
      end else begin
        w_state_nxt  = ST_IDLE;
        w_grant_nxt  = '0;
        w_credit_nxt = '0;
      end
    end else if (w_own_xfr) begin
      w_credit_nxt = r_credit - WT_W'(1);
    end
  end

`ifdef WRR_TIMEOUT_EN
  localparam int unsigned HW = $clog2(TIMEOUT) + 1;
  logic [HW-1:0] r_hold;
  logic          r_timeout;

  assign w_hold_exp = w_owned && !w_own_xfr && (r_hold == HW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_hold_exp && w_own_req;
      if (!w_owned || w_own_xfr || w_release) r_hold <= '0;
      else                                    r_hold <= r_hold + HW'(1);
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT);
  assign w_hold_exp       = 1'b0;
  assign bus.timeout      = 1'b0;
`endif

  assign bus.m_grant = r_grant;

  assign w_addr = bus.m_addr[r_owner*AW +: AW];
  assign w_hit  = (w_addr[31:16] == BASE_HI) && (w_addr[11:8] == WIN_ID) &&
                  (32'(w_addr[15:12]) < NUM_S);

  // Routing follows the registered owner only.
  always_comb begin
    bus.s_sel   = '0;
    bus.s_rw    = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.m_rdata = '0;
    bus.dec_err = 1'b0;
    if (w_owned) begin
      bus.s_rw    = {NUM_S{bus.m_rw[r_owner]}};
      bus.s_addr  = w_addr;
      bus.s_wdata = bus.m_wdata[r_owner*DW +: DW];
      bus.dec_err = !w_hit;
      for (int unsigned s = 0; s < NUM_S; s++) begin
        if (w_hit && (w_addr[15:12] == 4'(s))) begin
          bus.s_sel[s]                   = 1'b1;
          bus.m_rdata[r_owner*DW +: DW]  = bus.s_rdata[s*DW +: DW];
        end
      end
    end
  end
endmodule
